// File: rtl/bp_pkg.sv
// Shared definitions for the dynamic branch predictor.
//   - idx_w_f : index width from the table depth
//   - ctr_inc / ctr_dec : saturating counter helpers; the width is passed as an argument
//   - btb_entry_t : one BTB entry {valid, tag, target}. The tag field is sized for the
//     widest legal tag, and narrower tags are stored zero-extended.
package bp_pkg;

   localparam int unsigned BP_TAG_MAX = 30;

   typedef struct packed {
      logic                  valid;
      logic [BP_TAG_MAX-1:0] tag;
      logic [31:0]           target;
   } btb_entry_t;

   function automatic int unsigned idx_w_f(input int unsigned entries);
      return $clog2(entries);
   endfunction

   function automatic logic [31:0] ctr_max(input int unsigned w);
      if (w >= 32) return '1;
      return (32'd1 << w) - 32'd1;
   endfunction

   function automatic logic [31:0] ctr_inc(input logic [31:0] v, input int unsigned w);
      return (v == ctr_max(w)) ? v : v + 32'd1;
   endfunction

   function automatic logic [31:0] ctr_dec(input logic [31:0] v, input int unsigned w);
      return (v == 32'd0) ? v : v - 32'd1;
   endfunction

endpackage

// File: rtl/bp_sat_ctr_bank.sv
// Bank of ENTRIES saturating counters (the BHT).
// Ports:
//   clk, rst      clock, synchronous active-high reset (counters go weakly not-taken)
//   rd_idx_i      combinational read index  -> rd_ctr_o
//   upd_en_i      apply an update at upd_idx_i this edge
//   upd_idx_i     counter to train
//   upd_taken_i   1: saturating increment, 0: saturating decrement
module bp_sat_ctr_bank
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned CTR_W   = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [idx_w_f(ENTRIES)-1:0]   rd_idx_i,
   output logic [CTR_W-1:0]              rd_ctr_o,
   input  logic                          upd_en_i,
   input  logic [idx_w_f(ENTRIES)-1:0]   upd_idx_i,
   input  logic                          upd_taken_i
);

   // Weakly not-taken: 2^(CTR_W-1)-1, which is 0 for a 1-bit counter.
   localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((32'd1 << (CTR_W - 1)) - 32'd1);

   logic [CTR_W-1:0] ctr_q [ENTRIES];
   logic [CTR_W-1:0] ctr_d [ENTRIES];

   assign rd_ctr_o = ctr_q[rd_idx_i];

   always_comb begin
      ctr_d = ctr_q;
      if (upd_en_i) begin
         if (upd_taken_i)
            ctr_d[upd_idx_i] = CTR_W'(ctr_inc(32'(ctr_q[upd_idx_i]), CTR_W));
         else
            ctr_d[upd_idx_i] = CTR_W'(ctr_dec(32'(ctr_q[upd_idx_i]), CTR_W));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) ctr_q[i] <= CTR_RST;
      end else begin
         ctr_q <= ctr_d;
      end
   end

endmodule

// File: rtl/bp_dynamic.sv
// Dynamic branch predictor: a BHT of saturating counters plus a tagged BTB.
// The fetch stage looks it up combinationally with pc_i. Decode trains it with one
// resolved branch per cycle through upd_*.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   pc_i                         fetch PC for lookup
//   pred_taken_o / pred_hit_o    direction prediction / BTB valid and tag match
//   pred_target_o                predicted target, 0 unless predicted taken
//   upd_valid_i, upd_pc_i,
//   upd_taken_i, upd_target_i    resolved branch training port
//   flush_i                      invalidate every BTB entry (counters and history retained)
// Optional feature: define BP_GSHARE_EN to XOR a HIST_W-bit global history into the BHT index.
module bp_dynamic
   import bp_pkg::*;
#(
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned CTR_W   = 2,
   parameter int unsigned TAG_W   = 8,
   parameter int unsigned HIST_W  = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_i,
   output logic        pred_taken_o,
   output logic        pred_hit_o,
   output logic [31:0] pred_target_o,
   input  logic        upd_valid_i,
   input  logic [31:0] upd_pc_i,
   input  logic        upd_taken_i,
   input  logic [31:0] upd_target_i,
   input  logic        flush_i
);

   localparam int unsigned IDX_W = idx_w_f(ENTRIES);

   btb_entry_t btb_q [ENTRIES];
   btb_entry_t btb_d [ENTRIES];

   logic [IDX_W-1:0] lk_btb_idx, lk_bht_idx, upd_btb_idx, upd_bht_idx;
   logic [TAG_W-1:0] lk_tag, upd_tag;
   logic [CTR_W-1:0] lk_ctr;
   btb_entry_t       lk_entry;

   assign lk_btb_idx  = pc_i[IDX_W+1:2];
   assign upd_btb_idx = upd_pc_i[IDX_W+1:2];
   assign lk_tag      = pc_i[IDX_W+TAG_W+1:IDX_W+2];
   assign upd_tag     = upd_pc_i[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BP_GSHARE_EN
   // Non-speculative history. Lookup and update both see the pre-shift value.
   logic [HIST_W-1:0] hist_q, hist_d;

   assign lk_bht_idx  = lk_btb_idx ^ IDX_W'(hist_q);
   assign upd_bht_idx = upd_btb_idx ^ IDX_W'(hist_q);

   // The truncating cast handles HIST_W=1, where hist simply becomes upd_taken_i.
   always_comb begin
      hist_d = hist_q;
      if (upd_valid_i) hist_d = HIST_W'({hist_q, upd_taken_i});
   end

   always_ff @(posedge clk) begin
      if (rst) hist_q <= '0;
      else     hist_q <= hist_d;
   end
`else
   localparam int unsigned unused_hist_w = HIST_W;

   assign lk_bht_idx  = lk_btb_idx;
   assign upd_bht_idx = upd_btb_idx;
`endif

   bp_sat_ctr_bank #(
      .ENTRIES (ENTRIES),
      .CTR_W   (CTR_W)
   ) u_ctr_bank (
      .clk         (clk),
      .rst         (rst),
      .rd_idx_i    (lk_bht_idx),
      .rd_ctr_o    (lk_ctr),
      .upd_en_i    (upd_valid_i),
      .upd_idx_i   (upd_bht_idx),
      .upd_taken_i (upd_taken_i)
   );

   // Lookup sees pre-update state. There is no bypass from the update port.
   always_comb begin
      lk_entry      = btb_q[lk_btb_idx];
      pred_hit_o    = lk_entry.valid && (lk_entry.tag == BP_TAG_MAX'(lk_tag));
      pred_taken_o  = pred_hit_o && lk_ctr[CTR_W-1];
      pred_target_o = pred_taken_o ? lk_entry.target : 32'd0;
   end

   // Taken updates overwrite the entry, including an aliasing one. A flush in the same
   // cycle is applied afterwards, so it wins over the valid bit.
   always_comb begin
      btb_d = btb_q;
      if (upd_valid_i && upd_taken_i) begin
         btb_d[upd_btb_idx].valid  = 1'b1;
         btb_d[upd_btb_idx].tag    = BP_TAG_MAX'(upd_tag);
         btb_d[upd_btb_idx].target = upd_target_i;
      end
      if (flush_i) begin
         for (int i = 0; i < int'(ENTRIES); i++) btb_d[i].valid = 1'b0;
      end
   end

   // Reset clears only the valid bits. Tags and targets are don't-care until written.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(ENTRIES); i++) btb_q[i].valid <= 1'b0;
      end else begin
         btb_q <= btb_d;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{pc_i, upd_pc_i, lk_ctr};

endmodule
